// File: rtl/sensor_poll_controller_if.sv
// Byte-level I2C master request/response bundle used by the sensor poller.
interface sensor_poll_controller_if;
   logic       ena;
   logic [7:0] addr;
   logic [7:0] sub_addr;
   logic [7:0] data_wr;
   logic [7:0] data_rd;
   logic       busy;
   logic       ack_err;

   // Poller side: issues byte requests, observes completion.
   modport master (
      output ena, addr, sub_addr, data_wr,
      input  data_rd, busy, ack_err
   );

   // I2C master side: accepts requests, reports busy/data/NACK.
   modport slave (
      input  ena, addr, sub_addr, data_wr,
      output data_rd, busy, ack_err
   );
endinterface

// File: rtl/sensor_poll_controller.sv
// Sensor poller: one-time control-register write, then periodic multi-byte
// reads of NUM_CH channels with per-channel value/delta/min/max tracking.
module sensor_poll_controller #(
   parameter int unsigned          NUM_CH       = 2,
   parameter int unsigned          DATA_W       = 20,
   parameter int unsigned          BYTES_PER_CH = 3,
   parameter logic [7:0]           DEV_ADDR     = 8'hC0,
   parameter logic [NUM_CH*8-1:0]  CH_BASE      = {8'h04, 8'h01},
   parameter logic [NUM_CH-1:0]    SIGNED_MASK  = 2'b10,
   parameter logic [7:0]           CTRL_SUB     = 8'h26,
   parameter logic [7:0]           CTRL_VAL     = 8'h39,
   parameter int unsigned          POLL_DIV     = 1_000_000,
   parameter int unsigned          TIMEOUT      = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear_minmax,
   output logic [NUM_CH*DATA_W-1:0]   value,
   output logic [NUM_CH*DATA_W-1:0]   delta,
   output logic [NUM_CH*DATA_W-1:0]   min_val,
   output logic [NUM_CH*DATA_W-1:0]   max_val,
   output logic [NUM_CH-1:0]          sample_stb,
   output logic                       err,
   output logic [7:0]                 err_count,
   sensor_poll_controller_if.master   i2c
);

   localparam int unsigned ASM_W = BYTES_PER_CH * 8;
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned BY_W  = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
   localparam int unsigned PC_W  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      INIT_REQ,
      INIT_WAIT,
      IDLE,
      RD_REQ,
      RD_WAIT,
      UPDATE,
      NEXT_CH
   } state_e;

   state_e            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [BY_W-1:0]   byte_q, byte_d;
   logic              init_pend_q, init_pend_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic [PC_W-1:0]   pcnt_q;

   logic              tick;
   logic              tmo;
   logic              xfer_err;
   logic              byte_ok;
   logic              pcnt_clr;
   logic              last_byte;
   logic              last_ch;

   logic              ena_q;
   logic [7:0]        addr_q;
   logic [7:0]        sub_q;
   logic [7:0]        wr_q;
   logic [7:0]        base_sel;

   logic [ASM_W-1:0]  asm_q;
   logic [DATA_W-1:0] value_q [NUM_CH];
   logic [DATA_W-1:0] delta_q [NUM_CH];
   logic [DATA_W-1:0] min_q   [NUM_CH];
   logic [DATA_W-1:0] max_q   [NUM_CH];
   logic [NUM_CH-1:0] seeded_q;
   logic [NUM_CH-1:0] stb_q;
   logic              err_q;
   logic [7:0]        err_cnt_q;

   logic [DATA_W-1:0] sample;
   logic              sgn;
   logic              lt_min;
   logic              gt_max;

   assign tick      = (pcnt_q == PC_W'(POLL_DIV - 1));
   assign tmo       = (tcnt_q == TO_W'(TIMEOUT - 1));
   assign last_byte = (byte_q == BY_W'(BYTES_PER_CH - 1));
   assign last_ch   = (ch_q == CH_W'(NUM_CH - 1));
   assign base_sel  = CH_BASE[{ch_d, 3'b000} +: 8];

   // State register and sequencing counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= INIT_REQ;
         ch_q        <= '0;
         byte_q      <= '0;
         init_pend_q <= 1'b0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         byte_q      <= byte_d;
         init_pend_q <= init_pend_d;
         tcnt_q      <= tcnt_d;
      end
   end

   // Next-state logic, byte handshake and error detection.
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      byte_d      = byte_q;
      init_pend_d = init_pend_q;
      xfer_err    = 1'b0;
      byte_ok     = 1'b0;
      pcnt_clr    = 1'b0;

      unique case (state_q)
         INIT_REQ: begin
            if (i2c.busy) begin
               state_d = INIT_WAIT;
            end else if (tmo) begin
               xfer_err    = 1'b1;
               init_pend_d = 1'b1;
               pcnt_clr    = 1'b1;
               state_d     = IDLE;
            end
         end
         INIT_WAIT: begin
            if (!i2c.busy) begin
               state_d = IDLE;
               if (i2c.ack_err) begin
                  xfer_err    = 1'b1;
                  init_pend_d = 1'b1;
                  pcnt_clr    = 1'b1;
               end else begin
                  init_pend_d = 1'b0;
               end
            end else if (tmo) begin
               xfer_err    = 1'b1;
               init_pend_d = 1'b1;
               pcnt_clr    = 1'b1;
               state_d     = IDLE;
            end
         end
         IDLE: begin
            if (tick) begin
               if (init_pend_q) begin
                  state_d = INIT_REQ;
               end else begin
                  ch_d    = '0;
                  byte_d  = '0;
                  state_d = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (i2c.busy) begin
               state_d = RD_WAIT;
            end else if (tmo) begin
               xfer_err = 1'b1;
               state_d  = NEXT_CH;
            end
         end
         RD_WAIT: begin
            if (!i2c.busy) begin
               if (i2c.ack_err) begin
                  xfer_err = 1'b1;
                  state_d  = NEXT_CH;
               end else begin
                  byte_ok = 1'b1;
                  if (last_byte) begin
                     state_d = UPDATE;
                  end else begin
                     byte_d  = byte_q + BY_W'(1);
                     state_d = RD_REQ;
                  end
               end
            end else if (tmo) begin
               xfer_err = 1'b1;
               state_d  = NEXT_CH;
            end
         end
         UPDATE: begin
            state_d = NEXT_CH;
         end
         NEXT_CH: begin
            if (last_ch) begin
               state_d = IDLE;
            end else begin
               ch_d    = ch_q + CH_W'(1);
               byte_d  = '0;
               state_d = RD_REQ;
            end
         end
         default: begin
            state_d = INIT_REQ;
         end
      endcase

      // Timeout budget restarts on every state change, so rise and fall
      // of busy are each given the full window.
      tcnt_d = '0;
      if ((state_d == state_q) &&
          ((state_q == INIT_REQ) || (state_q == INIT_WAIT) ||
           (state_q == RD_REQ)   || (state_q == RD_WAIT))) begin
         tcnt_d = tcnt_q + TO_W'(1);
      end
   end

   // Free-running frame divider; restarted on an init failure so the retry
   // comes a full period later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt_q <= '0;
      end else if (pcnt_clr || tick) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + PC_W'(1);
      end
   end

   // Request outputs registered from the next state so ena falls one cycle
   // after busy is observed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ena_q  <= 1'b0;
         addr_q <= '0;
         sub_q  <= '0;
         wr_q   <= '0;
      end else begin
         ena_q <= (state_d == INIT_REQ) || (state_d == RD_REQ);
         if (state_d == INIT_REQ) begin
            addr_q <= DEV_ADDR;
            sub_q  <= CTRL_SUB;
            wr_q   <= CTRL_VAL;
         end else if (state_d == RD_REQ) begin
            addr_q <= DEV_ADDR | 8'h01;
            sub_q  <= base_sel + 8'(byte_d);
            wr_q   <= '0;
         end
      end
   end

   assign sample = DATA_W'(asm_q >> (ASM_W - DATA_W));
   assign sgn    = SIGNED_MASK[ch_q];
   assign lt_min = sgn ? ($signed(sample) < $signed(min_q[ch_q])) : (sample < min_q[ch_q]);
   assign gt_max = sgn ? ($signed(sample) > $signed(max_q[ch_q])) : (sample > max_q[ch_q]);

   // Byte assembly and per-channel statistics update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         asm_q    <= '0;
         seeded_q <= '0;
         stb_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            value_q[i] <= '0;
            delta_q[i] <= '0;
            min_q[i]   <= '0;
            max_q[i]   <= '0;
         end
      end else begin
         stb_q <= '0;
         if (byte_ok) begin
            asm_q <= ASM_W'({asm_q, i2c.data_rd});
         end
         if (clear_minmax) begin
            seeded_q <= '0;
         end
         if (state_q == UPDATE) begin
            stb_q[ch_q]    <= 1'b1;
            seeded_q[ch_q] <= 1'b1;
            value_q[ch_q]  <= sample;
            if (!seeded_q[ch_q] || clear_minmax) begin
               delta_q[ch_q] <= '0;
               min_q[ch_q]   <= sample;
               max_q[ch_q]   <= sample;
            end else begin
               delta_q[ch_q] <= sample - value_q[ch_q];
               if (lt_min) begin
                  min_q[ch_q] <= sample;
               end
               if (gt_max) begin
                  max_q[ch_q] <= sample;
               end
            end
         end
      end
   end

   // Error pulse and saturating error counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q <= xfer_err;
         if (xfer_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign value[DATA_W*g +: DATA_W]   = value_q[g];
      assign delta[DATA_W*g +: DATA_W]   = delta_q[g];
      assign min_val[DATA_W*g +: DATA_W] = min_q[g];
      assign max_val[DATA_W*g +: DATA_W] = max_q[g];
   end

   assign sample_stb   = stb_q;
   assign err          = err_q;
   assign err_count    = err_cnt_q;
   assign i2c.ena      = ena_q;
   assign i2c.addr     = addr_q;
   assign i2c.sub_addr = sub_q;
   assign i2c.data_wr  = wr_q;

endmodule

// File: tb/tb_sensor_poll_controller.sv
// Bench for sensor_poll_controller: scripted I2C master model plus a
// channel-level reference of value/delta/min/max/error behaviour.
`timescale 1ns/1ps
module tb_sensor_poll_controller;
   localparam int unsigned NUM_CH = 2;
   localparam int unsigned DATA_W = 20;
   localparam int unsigned BYTES  = 3;

   logic clk = 1'b0;
   logic rst;
   logic clear_minmax;
   logic [NUM_CH*DATA_W-1:0] value, delta, min_val, max_val;
   logic [NUM_CH-1:0] sample_stb;
   logic err;
   logic [7:0] err_count;

   sensor_poll_controller_if ifc();

   sensor_poll_controller #(.POLL_DIV(16), .TIMEOUT(32)) dut (
      .clk(clk), .rst(rst), .clear_minmax(clear_minmax),
      .value(value), .delta(delta), .min_val(min_val), .max_val(max_val),
      .sample_stb(sample_stb), .err(err), .err_count(err_count), .i2c(ifc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] addr; logic [7:0] sub; logic [7:0] wr; bit chk_wr;
      logic [7:0] d; bit nack; bit hang; int lat;
   } txn_t;
   txn_t resp_q[$];
   bit   slave_idle = 1'b1;
   int   hang_cyc = 0;
   logic hang_err = 1'b0;

   logic [15:0] ch_base  = 16'h0401;
   logic [1:0]  sgn_mask = 2'b10;

   // Reference state
   bit          seeded_m [NUM_CH];
   logic [DATA_W-1:0] val_m [NUM_CH], del_m [NUM_CH], min_m [NUM_CH], max_m [NUM_CH];
   int          err_m = 0;

   logic [23:0] fr_raw [NUM_CH];
   int          fr_nack [NUM_CH];
   bit          fr_hang [NUM_CH];

   int stb_cnt [NUM_CH];
   int err_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse monitor for strobes and error pulses
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) stb_cnt[i] += int'(sample_stb[i]);
         err_cnt += int'(err);
      end
   end

   // Scripted I2C master: each request consumes one queued response
   initial begin : slave
      txn_t e; int t0; int w; logic [7:0] a, s, wd;
      ifc.busy = 1'b0; ifc.ack_err = 1'b0; ifc.data_rd = 8'h00;
      forever begin
         @(negedge clk);
         ifc.ack_err = 1'b0;
         if (rst && ifc.ena) begin
            a = ifc.addr; s = ifc.sub_addr; wd = ifc.data_wr; t0 = cyc;
            w = 0;
            while (resp_q.size() == 0 && w < 20 && rst) begin @(negedge clk); w++; end
            if (resp_q.size() == 0 || !rst) begin
               w = 0;
               while (ifc.ena && rst && w < 100) begin @(negedge clk); w++; end
            end else begin
               e = resp_q.pop_front();
               slave_idle = 1'b0;
               chk("txn_addr", 32'(a), 32'(e.addr));
               chk("txn_sub", 32'(s), 32'(e.sub));
               if (e.chk_wr) chk("txn_wr", 32'(wd), 32'(e.wr));
               if (e.hang) begin
                  while (ifc.ena && rst && (cyc - t0) < 200) @(negedge clk);
                  hang_cyc = cyc - t0;
                  hang_err = err;
               end else begin
                  ifc.busy = 1'b1;
                  @(negedge clk);
                  if (rst) chk("ena_drop", 32'(ifc.ena), 32'd0);
                  for (int k = 0; k < e.lat && rst; k++) begin
                     @(negedge clk);
                     if (rst) chk("ena_in_wait", 32'(ifc.ena), 32'd0);
                  end
                  ifc.data_rd = e.d;
                  ifc.ack_err = e.nack;
                  ifc.busy    = 1'b0;
               end
               slave_idle = 1'b1;
            end
         end
      end
   end

   function automatic longint num(input int c, input logic [DATA_W-1:0] v);
      longint x = longint'(v);
      if (sgn_mask[c] && v[DATA_W-1]) x -= (longint'(1) << DATA_W);
      return x;
   endfunction

   function automatic void model_sample(input int c, input logic [DATA_W-1:0] s);
      if (!seeded_m[c]) begin
         val_m[c] = s; min_m[c] = s; max_m[c] = s; del_m[c] = '0; seeded_m[c] = 1'b1;
      end else begin
         del_m[c] = DATA_W'(s - val_m[c]);
         if (num(c, s) < num(c, min_m[c])) min_m[c] = s;
         if (num(c, s) > num(c, max_m[c])) max_m[c] = s;
         val_m[c] = s;
      end
   endfunction

   task automatic wait_idle();
      int w = 0;
      while ((resp_q.size() != 0 || !slave_idle) && w < 3000) begin @(negedge clk); w++; end
      chk("wait_idle_bound", 32'(w < 3000), 32'd1);
   endtask

   task automatic check_outputs();
      for (int c = 0; c < NUM_CH; c++) begin
         chk($sformatf("value%0d", c), 32'(value[DATA_W*c +: DATA_W]), 32'(val_m[c]));
         chk($sformatf("delta%0d", c), 32'(delta[DATA_W*c +: DATA_W]), 32'(del_m[c]));
         chk($sformatf("min%0d", c), 32'(min_val[DATA_W*c +: DATA_W]), 32'(min_m[c]));
         chk($sformatf("max%0d", c), 32'(max_val[DATA_W*c +: DATA_W]), 32'(max_m[c]));
      end
      chk("err_count", 32'(err_count), 32'(err_m > 255 ? 255 : err_m));
   endtask

   task automatic run_frame();
      txn_t e;
      int s0 [NUM_CH];
      int e0;
      int exp_err = 0;
      for (int c = 0; c < NUM_CH; c++) s0[c] = stb_cnt[c];
      e0 = err_cnt;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int b = 0; b < BYTES; b++) begin
            e.addr = 8'hC1; e.sub = ch_base[8*c +: 8] + 8'(b);
            e.wr = 8'h00; e.chk_wr = 1'b0;
            e.d = fr_raw[c][8*(BYTES-1-b) +: 8];
            e.nack = (fr_nack[c] == b);
            e.hang = fr_hang[c] && (b == 0);
            e.lat = int'($urandom_range(0, 3));
            resp_q.push_back(e);
            if (e.nack || e.hang) break;
         end
      end
      wait_idle();
      repeat (8) @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
         if (fr_nack[c] >= 0 || fr_hang[c]) begin
            err_m++; exp_err++;
            chk($sformatf("stb_count%0d", c), 32'(stb_cnt[c] - s0[c]), 32'd0);
         end else begin
            model_sample(c, DATA_W'(fr_raw[c] >> 4));
            chk($sformatf("stb_count%0d", c), 32'(stb_cnt[c] - s0[c]), 32'd1);
         end
      end
      chk("err_pulses", 32'(err_cnt - e0), 32'(exp_err));
      check_outputs();
   endtask

   task automatic set_frame(input logic [23:0] r0, input logic [23:0] r1,
                            input int n0, input int n1, input bit h0);
      fr_raw[0] = r0; fr_raw[1] = r1;
      fr_nack[0] = n0; fr_nack[1] = n1;
      fr_hang[0] = h0; fr_hang[1] = 1'b0;
   endtask

   initial begin : main
      txn_t e;
      int w;
      for (int c = 0; c < NUM_CH; c++) begin
         seeded_m[c] = 1'b0; val_m[c] = '0; del_m[c] = '0; min_m[c] = '0; max_m[c] = '0;
         stb_cnt[c] = 0;
      end
      rst = 1'b0; clear_minmax = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_value", 32'(|{value, delta}), 32'd0);
      chk("rst_minmax", 32'(|{min_val, max_val}), 32'd0);
      chk("rst_ctl", 32'({sample_stb, err, err_count, ifc.ena}), 32'd0);

      // Control-register write comes first
      e.addr = 8'hC0; e.sub = 8'h26; e.wr = 8'h39; e.chk_wr = 1'b1;
      e.d = 8'h00; e.nack = 1'b0; e.hang = 1'b0; e.lat = 1;
      resp_q.push_back(e);
      rst = 1'b1;
      wait_idle();
      repeat (4) @(negedge clk);
      chk("init_err_count", 32'(err_count), 32'd0);

      // First samples seed both channels
      set_frame(24'h123456, 24'h000100, -1, -1, 1'b0);
      run_frame();
      chk("f1_value0", 32'(value[19:0]), 32'h12345);
      chk("f1_delta0", 32'(delta[19:0]), 32'h0);

      // Unsigned decrease on ch0, signed wrap on ch1
      set_frame(24'h123000, 24'hFFFF00, -1, -1, 1'b0);
      run_frame();
      chk("f2_delta0", 32'(delta[19:0]), 32'hFFFBB);
      chk("f2_min0", 32'(min_val[19:0]), 32'h12300);
      chk("f2_max0", 32'(max_val[19:0]), 32'h12345);
      chk("f2_min1", 32'(min_val[39:20]), 32'hFFFF0);
      chk("f2_max1", 32'(max_val[39:20]), 32'h00010);
      chk("f2_delta1", 32'(delta[39:20]), 32'hFFFE0);

      // NACK on last byte of ch0; ch1 still updates
      set_frame(24'hABCDEF, 24'h00A5A0, 2, -1, 1'b0);
      run_frame();

      // busy never rises for ch0 byte 0
      set_frame(24'h111111, 24'h222220, -1, -1, 1'b1);
      run_frame();
      chk("hang_cycles", 32'(hang_cyc), 32'd32);
      chk("hang_err_at_drop", 32'(hang_err), 32'd1);

      // Randomised frames with occasional NACKs and min/max clears
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk); clear_minmax = 1'b1;
            @(negedge clk); clear_minmax = 1'b0;
            for (int c = 0; c < NUM_CH; c++) seeded_m[c] = 1'b0;
         end
         set_frame(24'($urandom), 24'($urandom),
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : -1, 1'b0);
         run_frame();
      end

      // Asynchronous reset while a read byte is outstanding
      e.addr = 8'hC1; e.sub = 8'h01; e.wr = 8'h00; e.chk_wr = 1'b0;
      e.d = 8'h55; e.nack = 1'b0; e.hang = 1'b0; e.lat = 10;
      resp_q.push_back(e);
      w = 0;
      while (!ifc.busy && w < 500) begin @(negedge clk); w++; end
      chk("rd_busy_bound", 32'(w < 500), 32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_value", 32'(|{value, delta}), 32'd0);
      chk("arst_minmax", 32'(|{min_val, max_val}), 32'd0);
      chk("arst_ctl", 32'({sample_stb, err, err_count, ifc.ena}), 32'd0);
      for (int c = 0; c < NUM_CH; c++) begin
         seeded_m[c] = 1'b0; val_m[c] = '0; del_m[c] = '0; min_m[c] = '0; max_m[c] = '0;
      end
      err_m = 0;
      e.addr = 8'hC0; e.sub = 8'h26; e.wr = 8'h39; e.chk_wr = 1'b1;
      e.d = 8'h00; e.nack = 1'b0; e.hang = 1'b0; e.lat = 0;
      resp_q.push_back(e);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_idle();
      repeat (4) @(negedge clk);
      check_outputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
